// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver assembling bytes into a parallel word
module uart_rx #(
    parameter int output_width   = 48,
    parameter int cycles_per_bit = 391,
    parameter int timeout_bits   = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    serial_in,
    output logic [output_width-1:0] bus_out,
    output logic                    valid,
    output logic                    frame_error,
    output logic                    busy
);

    // Mid-bit offset used to centre the start-bit sample; later bits step a full period.
    localparam logic [15:0] HALF       = 16'((cycles_per_bit - 1) / 2);
    localparam logic [15:0] BIT_LAST   = 16'(cycles_per_bit - 1);
    localparam logic [25:0] TIMEOUT_LAST = 26'(timeout_bits * cycles_per_bit - 1);
    localparam logic [2:0]  BYTE_LAST  = 3'(output_width / 8 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                  state_q,       state_d;
    logic                    sync_meta_q,   sync_meta_d;
    logic                    rx_s_q,        rx_s_d;
    logic [15:0]             clk_cnt_q,     clk_cnt_d;
    logic [2:0]              bit_idx_q,     bit_idx_d;
    logic [2:0]              byte_idx_q,    byte_idx_d;
    logic [7:0]              shift_q,       shift_d;
    logic [output_width-1:0] word_q,        word_d;
    logic [25:0]             idle_cnt_q,    idle_cnt_d;
    logic [output_width-1:0] bus_out_q,     bus_out_d;
    logic                    valid_q,       valid_d;
    logic                    frame_error_q, frame_error_d;
    logic                    busy_q,        busy_d;

    // Next-state logic: synchronizer shift, bit timing, byte/word assembly and error detection.
    always_comb begin
        state_d       = state_q;
        sync_meta_d   = serial_in;
        rx_s_d        = sync_meta_q;
        clk_cnt_d     = clk_cnt_q;
        bit_idx_d     = bit_idx_q;
        byte_idx_d    = byte_idx_q;
        shift_d       = shift_q;
        word_d        = word_q;
        idle_cnt_d    = idle_cnt_q;
        bus_out_d     = bus_out_q;
        valid_d       = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d    = START;
                    clk_cnt_d  = '0;
                    idle_cnt_d = '0;
                end else if (byte_idx_q != 3'd0) begin
                    // A partial word that sits too long is dropped and flagged.
                    if (idle_cnt_q == TIMEOUT_LAST) begin
                        frame_error_d = 1'b1;
                        byte_idx_d    = 3'd0;
                        idle_cnt_d    = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 26'd1;
                    end
                end
            end
            START: begin
                if (clk_cnt_q == HALF) begin
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        clk_cnt_d = '0;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line went back high before mid start bit: treat as a glitch.
                        state_d = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    shift_d[bit_idx_q] = rx_s_q;
                    clk_cnt_d          = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        word_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
                        state_d = IDLE;
                        if (byte_idx_q == BYTE_LAST) begin
                            bus_out_d  = word_d;
                            valid_d    = 1'b1;
                            byte_idx_d = 3'd0;
                        end else begin
                            byte_idx_d = byte_idx_q + 3'd1;
                        end
                    end else begin
                        frame_error_d = 1'b1;
                        byte_idx_d    = 3'd0;
                        state_d       = WAIT_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            WAIT_IDLE: begin
                // Hold off until the line returns high so a break is not read as start bits.
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == START) || (state_d == DATA) || (state_d == STOP) ||
                 (byte_idx_d != 3'd0);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sync_meta_q   <= 1'b1;
            rx_s_q        <= 1'b1;
            clk_cnt_q     <= '0;
            bit_idx_q     <= 3'd0;
            byte_idx_q    <= 3'd0;
            shift_q       <= '0;
            word_q        <= '0;
            idle_cnt_q    <= '0;
            bus_out_q     <= '0;
            valid_q       <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_meta_q   <= sync_meta_d;
            rx_s_q        <= rx_s_d;
            clk_cnt_q     <= clk_cnt_d;
            bit_idx_q     <= bit_idx_d;
            byte_idx_q    <= byte_idx_d;
            shift_q       <= shift_d;
            word_q        <= word_d;
            idle_cnt_q    <= idle_cnt_d;
            bus_out_q     <= bus_out_d;
            valid_q       <= valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    assign bus_out     = bus_out_q;
    assign valid       = valid_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;

endmodule
